// File: rtl/avmm_copy_pkg.sv
// rtl/avmm_copy_pkg.sv - shared types and constants for the Avalon-MM block copy master
package avmm_copy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DONE
  } copy_state_t;

  localparam int DATA_W = 32;
  localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/avmm_copy_fifo.sv
// rtl/avmm_copy_fifo.sv - synchronous read-data FIFO with occupancy count and async active-high reset
module avmm_copy_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/avmm_block_copy_master.sv
// rtl/avmm_block_copy_master.sv - Avalon-MM block copy master; AVMM_COPY_CHECKSUM_EN adds a running checksum output
module avmm_block_copy_master
  import avmm_copy_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef AVMM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  copy_state_t       state, next_state;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CNT_W-1:0]  cnt_q, rd_cnt, wr_cnt;
  logic [CW-1:0]     outstanding;
  logic              pend_q, pend_wr;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_flight;
  logic              write_ok, read_ok, cmd_read, cmd_write;
  logic              rd_acc, wr_acc, rd_rsp, start_ok;

  // A stalled command keeps its type even if read data lands in the FIFO meanwhile;
  // its address cannot move because the counters only advance on acceptance.
  always_comb begin
    in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
    write_ok  = (state == COPY) && (fifo_count != '0);
    read_ok   = (state == COPY) && (rd_cnt < cnt_q) && (in_flight < (CW+1)'(FIFO_DEPTH));
    if (pend_q) begin
      cmd_write = pend_wr;
      cmd_read  = !pend_wr;
    end else begin
      cmd_write = write_ok;
      cmd_read  = !write_ok && read_ok;
    end
    rd_acc   = cmd_read && !avm_waitrequest;
    wr_acc   = cmd_write && !avm_waitrequest;
    rd_rsp   = (state == COPY) && avm_readdatavalid;
    start_ok = (state == IDLE) && start;

    avm_read       = cmd_read;
    avm_write      = cmd_write;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = 4'h0;
    if (cmd_write) begin
      avm_address    = dst_q + ADDR_W'(wr_cnt);
      avm_writedata  = fifo_head;
      avm_byteenable = BYTEEN_ALL;
    end else if (cmd_read) begin
      avm_address    = src_q + ADDR_W'(rd_cnt);
      avm_byteenable = BYTEEN_ALL;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (word_count == '0) ? DONE : COPY;
      COPY:    if (wr_acc && (wr_cnt + CNT_W'(1) == cnt_q)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      outstanding <= '0;
      pend_q      <= 1'b0;
      pend_wr     <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != IDLE);
      done_q <= (state == DONE);
      if (start_ok) begin
        src_q       <= src_addr;
        dst_q       <= dst_addr;
        cnt_q       <= word_count;
        rd_cnt      <= '0;
        wr_cnt      <= '0;
        outstanding <= '0;
        pend_q      <= 1'b0;
        pend_wr     <= 1'b0;
      end else if (state == COPY) begin
        if (rd_acc) rd_cnt <= rd_cnt + CNT_W'(1);
        if (wr_acc) wr_cnt <= wr_cnt + CNT_W'(1);
        if (rd_acc && !rd_rsp)      outstanding <= outstanding + CW'(1);
        else if (!rd_acc && rd_rsp) outstanding <= outstanding - CW'(1);
        pend_q  <= (cmd_read || cmd_write) && avm_waitrequest;
        pend_wr <= cmd_write;
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  avmm_copy_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_rsp),
    .pop   (wr_acc),
    .wdata (avm_readdata),
    .head  (fifo_head),
    .count (fifo_count)
  );

`ifdef AVMM_COPY_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (wr_acc)   checksum <= checksum + fifo_head;
  end
`endif

endmodule

// File: tb/tb_avmm_block_copy_master.sv
// tb/tb_avmm_block_copy_master.sv - self-checking bench for avmm_block_copy_master with a behavioural Avalon-MM slave
module tb_avmm_block_copy_master;

  localparam int ADDR_W = 15;
  localparam int CNT_W = 16;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic busy, done, avm_read, avm_write;
  logic [ADDR_W-1:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0] avm_byteenable;
  logic avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic avm_readdatavalid = 1'b0;
`ifdef AVMM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  initial forever #5 clk = ~clk;

  avmm_block_copy_master #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
`ifdef AVMM_COPY_CHECKSUM_EN
    .checksum          (checksum),
`endif
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  typedef struct {
    logic [31:0] data;
    int due;
  } rsp_t;

  typedef struct {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0] cnt;
    int wait_pct;
    int lat_lo;
    int lat_hi;
    int pat;
    bit overlap;
    logic [ADDR_W-1:0] exp_last_rd;
    logic [ADDR_W-1:0] exp_last_wr;
  } vec_t;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  rsp_t rq[$];
  logic [ADDR_W-1:0] rd_addr_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0] rd_data_log[$];
  logic [31:0] wr_data_log[$];
  logic [ADDR_W+33:0] prev_cmd;
  bit prev_stalled, inject_rdv;
  int cyc, wait_pct, lat_lo, lat_hi;
  int n_out, max_out, done_cnt, stall_viol, both_viol, be_viol, db_viol, strobes;
  int n_err = 0;
  int n_chk = 0;
  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rd_addr_log.delete(); wr_addr_log.delete();
    rd_data_log.delete(); wr_data_log.delete();
    n_out = 0; max_out = 0; done_cnt = 0; stall_viol = 0;
    both_viol = 0; be_viol = 0; db_viol = 0; strobes = 0;
  endtask

  // Slave: responds in order, each read no earlier than its chosen latency.
  task automatic slave_step();
    rsp_t r;
    logic [ADDR_W+33:0] cur;
    bit stall;
    cyc++;
    if (reset) begin
      rq.delete();
      avm_readdatavalid = 1'b0;
      avm_waitrequest = 1'b0;
      prev_stalled = 1'b0;
      n_out = 0;
      return;
    end
    if (inject_rdv) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = 32'hDEAD_BEEF;
      inject_rdv = 1'b0;
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata = r.data;
      n_out--;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
    end
    if (done) done_cnt++;
    if (done && busy) db_viol++;
    if (avm_read && avm_write) both_viol++;
    cur = {avm_read, avm_write, avm_address, avm_writedata};
    if (prev_stalled && cur != prev_cmd) stall_viol++;
    if (avm_read || avm_write) begin
      strobes++;
      if (avm_byteenable != 4'hF) be_viol++;
    end else if (avm_byteenable != 4'h0) be_viol++;
    stall = ($urandom_range(99, 0) < wait_pct);
    avm_waitrequest = stall;
    if (avm_read && !stall) begin
      r.data = mem[avm_address];
      r.due = cyc + $urandom_range(lat_hi, lat_lo);
      rq.push_back(r);
      rd_addr_log.push_back(avm_address);
      rd_data_log.push_back(mem[avm_address]);
      n_out++;
      if (n_out > max_out) max_out = n_out;
    end
    if (avm_write && !stall) begin
      mem[avm_address] = avm_writedata;
      wr_addr_log.push_back(avm_address);
      wr_data_log.push_back(avm_writedata);
    end
    prev_stalled = (avm_read || avm_write) && stall;
    prev_cmd = cur;
  endtask

  initial forever begin
    @(negedge clk);
    slave_step();
  end

  task automatic start_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                            input logic [CNT_W-1:0] c);
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = ADDR_W'($urandom); dst_addr = ADDR_W'($urandom); word_count = CNT_W'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] snap[$];
    logic [ADDR_W-1:0] a;
    int k, aerr, derr, merr, nr, nw;
    for (int i = 0; i < int'(v.cnt); i++) begin
      a = ADDR_W'(v.src + i);
      mem[a] = (v.pat == 1) ? 32'(i * 3) : (v.pat == 2) ? 32'hFFFF_FFFF : $urandom;
      snap.push_back(mem[a]);
    end
    clear_mon();
    wait_pct = v.wait_pct; lat_lo = v.lat_lo; lat_hi = v.lat_hi;
    start_copy(v.src, v.dst, v.cnt);
    k = 0;
    while (done_cnt == 0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    nr = rd_addr_log.size();
    nw = wr_addr_log.size();
    aerr = 0; derr = 0; merr = 0;
    for (int i = 0; i < int'(v.cnt); i++) begin
      if (i < nr && rd_addr_log[i] != ADDR_W'(v.src + i)) aerr++;
      if (i < nw && wr_addr_log[i] != ADDR_W'(v.dst + i)) aerr++;
      if (i < nr && i < nw && wr_data_log[i] != rd_data_log[i]) derr++;
      if (!v.overlap && mem[ADDR_W'(v.dst + i)] != snap[i]) merr++;
    end
    check({tag, "_reads"}, nr, v.cnt);
    check({tag, "_writes"}, nw, v.cnt);
    check({tag, "_last_rd_addr"}, (nr > 0) ? rd_addr_log[nr-1] : '1, v.exp_last_rd);
    check({tag, "_last_wr_addr"}, (nw > 0) ? wr_addr_log[nw-1] : '1, v.exp_last_wr);
    check({tag, "_addr_seq_errs"}, aerr, 0);
    check({tag, "_data_order_errs"}, derr, 0);
    if (!v.overlap) check({tag, "_mem_errs"}, merr, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_stall_changes"}, stall_viol, 0);
    check({tag, "_outstanding_ok"}, (max_out <= FIFO_DEPTH) ? 1 : 0, 1);
    check({tag, "_rd_wr_both"}, both_viol, 0);
    check({tag, "_byteen_errs"}, be_viol, 0);
    check({tag, "_done_with_busy"}, db_viol, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{15'd0,     15'd100,   16'd8,  0,  1, 1, 1, 1'b0, 15'd7,    15'd107};
    vecs[1] = '{15'd200,   15'd1000,  16'd64, 50, 1, 5, 0, 1'b0, 15'd263,  15'd1063};
    vecs[2] = '{15'd32766, 15'd32767, 16'd4,  0,  1, 1, 0, 1'b1, 15'd1,    15'd2};
    vecs[3] = '{15'd5000,  15'd6000,  16'd20, 25, 2, 3, 0, 1'b0, 15'd5019, 15'd6019};
    vecs[4] = '{15'd32760, 15'd10,    16'd16, 10, 1, 4, 0, 1'b0, 15'd7,    15'd25};
    wait_pct = 0; lat_lo = 1; lat_hi = 1; inject_rdv = 1'b0;
    clear_mon();

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", avm_read, 0);
    check("rst_write", avm_write, 0);
    check("rst_address", avm_address, 0);
    check("rst_writedata", avm_writedata, 0);
    check("rst_byteenable", avm_byteenable, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    clear_mon();
    wait_pct = 0;
    start_copy('0, 15'd50, '0);
    check("zero_busy_c1", busy, 1);
    check("zero_done_c1", done, 0);
    @(negedge clk);
    check("zero_done_c2", done, 1);
    check("zero_busy_c2", busy, 0);
    @(negedge clk);
    check("zero_done_c3", done, 0);
    check("zero_strobes", strobes, 0);

    for (int i = 0; i < 32; i++) mem[300 + i] = $urandom;
    clear_mon();
    wait_pct = 0; lat_lo = 2; lat_hi = 2;
    start_copy(15'd300, 15'd2000, 16'd32);
    begin
      int k = 0;
      while (wr_addr_log.size() < 10 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      check("mid_reached_word10", (wr_addr_log.size() >= 10) ? 1 : 0, 1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_read", avm_read, 0);
    check("mid_rst_write", avm_write, 0);
    check("mid_rst_address", avm_address, 0);
    check("mid_rst_writedata", avm_writedata, 0);
    check("mid_rst_byteenable", avm_byteenable, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    inject_rdv = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_rdv_no_cmd", avm_read | avm_write, 0);
    run_vec('{15'd300, 15'd3000, 16'd32, 20, 1, 3, 0, 1'b0, 15'd331, 15'd3031}, "after_rst");

`ifdef AVMM_COPY_CHECKSUM_EN
    run_vec('{15'd400, 15'd500, 16'd2, 0, 1, 1, 2, 1'b0, 15'd401, 15'd501}, "csum");
    check("csum_value", checksum, 32'hFFFF_FFFE);
    start_copy('0, '0, '0);
    check("csum_cleared", checksum, 0);
    repeat (3) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
